servant_spi_ram_slave: RTL
==========================

# servant_spi_ram_slave

SPI responder that emulates a serial RAM behind a byte-wide memory port. It is the far end of the servant SPI master bridge: it decodes WREN/WRDI/RDSR/READ/WRITE transactions from an SPI mode-3 master and turns them into single-byte memory reads and writes. All SPI inputs are oversampled in the local `clock` domain, so the block runs with one clock and has no SCK-clocked logic. It is used as an on-chip RAM target in loopback benches and as an SPI-attached scratch RAM.

## Interface

- `ADDRESS_WIDTH`, 24: memory address width. 24 address bits are always received; bits above `ADDRESS_WIDTH-1` are ignored.
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `spi_sck` in 1: SPI clock, idles high (CPOL=1, CPHA=1), asynchronous to `clock`.
- `spi_ss` in 1: chip select, active low, asynchronous.
- `spi_mosi` in 1: master data, MSB first.
- `spi_miso` out 1: slave data, MSB first.
- `spi_miso_oe` out 1: high while `spi_ss` (synchronized) is low and the block is driving read or status data.
- `mem_addr` out ADDRESS_WIDTH: byte address.
- `mem_wdata` out 8: write byte.
- `mem_we` out 1: one-cycle write strobe.
- `mem_re` out 1: one-cycle read strobe.
- `mem_rdata` in 8: read data, valid exactly one `clock` after `mem_re`.

## Operation

- **Synchronization:** `spi_sck`, `spi_ss` and `spi_mosi` each pass through a 2-flop synchronizer.
- **Edge detection:** a rise of the synchronized SCK samples MOSI; a fall of the synchronized SCK shifts MISO.
- **Framing:** a fall of synchronized SS starts a transaction. A rise of synchronized SS returns the FSM to IDLE from any state within 1 cycle.
- **States:**
  - IDLE: SS low goes to CMD.
  - CMD: after 8 bits, decode the command:
    - 0x06 sets WEL, then goes to IGNORE.
    - 0x04 clears WEL, then goes to IGNORE.
    - 0x05 goes to STATUS.
    - 0x03 and 0x02 go to ADDR.
    - Anything else goes to IGNORE.
  - ADDR: 24 bits, MSB first, loaded into `mem_addr`. After the last bit:
    - READ goes to READ_DATA and pulses `mem_re` on the cycle after the 24th rising edge.
    - WRITE goes to WRITE_DATA.
  - READ_DATA: `mem_rdata` is captured into the TX shift register. Each byte's MSB is driven on the first SCK fall after the byte boundary. On the 8th rising edge of each byte, `mem_addr` is incremented and `mem_re` is pulsed to prefetch the next byte.
  - WRITE_DATA: on every 8th rising edge, the assembled byte goes to `mem_wdata`, `mem_we` is pulsed for 1 cycle if WEL=1 (suppressed if WEL=0), then `mem_addr` is incremented on the following cycle.
  - STATUS: shifts out {6'b0, WEL, 1'b0}. The same byte repeats for every further 8 clocks until SS rises.
  - IGNORE: MISO is 0 and `spi_miso_oe` is 0 until SS rises.
- **Address arithmetic:** `mem_addr` increments modulo 2^ADDRESS_WIDTH, so 0xFFFFFF wraps to 0x000000.
- **WEL:** a sticky register bit. Reset clears it. It is changed only by WREN or WRDI, and a write does not clear it.
- **Partial bytes:** if SS rises mid-byte, the partial byte is discarded, no `mem_we` is issued, and the bit counter resets.
- **Reset values:**
  - `spi_miso`=0, `spi_miso_oe`=0
  - `mem_we`=0, `mem_re`=0
  - `mem_addr`=0, `mem_wdata`=0
  - WEL=0, state IDLE
- **Reset mid-transaction:** aborts immediately. Memory is not written for the in-flight byte.

## Timing

- Input-to-decision latency is 2 cycles (synchronizer) plus 1 cycle (edge detect) = 3 `clock` cycles.
- Requirements on the master:
  - SCK high and SCK low phases are each ≥ 4 `clock` periods.
  - SS setup to the first SCK fall is ≥ 4 periods.
- MISO changes ≤ 4 `clock` periods after the SCK fall. It is stable at the next SCK rise whenever the low phase is ≥ 4 periods.
- The first read byte is loaded no later than 2 cycles after the 24th address rising edge, before the next SCK fall.
- `mem_we` occurs 1 cycle after the byte's 8th rising edge is detected.
- Continuous bursts have no byte-to-byte gap requirement beyond the SCK phase minimums.

## Configuration

- `SPI_RAM_SLAVE_WEL_EN` defined:
  - WEL gates writes as described above.
  - RDSR returns WEL in bit 1.
- `SPI_RAM_SLAVE_WEL_EN` undefined:
  - The WEL register is not built.
  - WRITE always produces `mem_we`.
  - 0x06 and 0x04 are accepted as no-ops (IGNORE).
  - RDSR returns 0x00.

## Test plan

- **Write with WEL:** reset, send 0x06, then 0x02 with address 0x000104 and data 0xA5 0x5A. Required: `mem_we` fires twice, at `mem_addr` 0x104 with 0xA5 and at 0x105 with 0x5A.
- **Read-back:** with the memory model holding the above, send 0x03 with address 0x000104 and clock 16 bits. Required: MISO shifts 0xA5 then 0x5A, and `spi_miso_oe`=1 throughout the data phase.
- **Write protection (macro defined):** reset, then 0x02 with address 0x000010 and data 0x33. Required: no `mem_we`. After 0x06, RDSR returns 0x02. After 0x04, RDSR returns 0x00.
- **Abort:** after WREN, send 0x02 with address 0x000020 and 5 data bits, then raise SS. Required: no `mem_we`, and the FSM is in IDLE 3 cycles after SS rises.
- **Wrap-around:** send 0x03 with address 0xFFFFFF and read 2 bytes. Required: `mem_re` is issued at 0xFFFFFF and then at 0x000000.
- **Unknown command and reset:** send command 0x9F. Required: MISO=0 and `spi_miso_oe`=0 for the whole frame. Assert `reset` mid-frame. Required: all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/servant_spi_ram_slave_if.sv
// Serial-RAM responder port bundle: SPI pins plus the byte-wide memory port.
// The slave modport is the responder's view; the master modport is the SPI host / memory side.
interface servant_spi_ram_slave_if #(
  parameter int ADDRESS_WIDTH = 24
);
  logic                     spi_sck;
  logic                     spi_ss;
  logic                     spi_mosi;
  logic                     spi_miso;
  logic                     spi_miso_oe;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [7:0]               mem_wdata;
  logic                     mem_we;
  logic                     mem_re;
  logic [7:0]               mem_rdata;

  modport slave (
    input  spi_sck, spi_ss, spi_mosi, mem_rdata,
    output spi_miso, spi_miso_oe, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output spi_sck, spi_ss, spi_mosi, mem_rdata,
    input  spi_miso, spi_miso_oe, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/servant_spi_ram_slave.sv
// SPI mode-3 serial-RAM responder, fully oversampled in the clock domain.
// Optional write-enable latch (WREN/WRDI/RDSR bit 1) is built when SPI_RAM_SLAVE_WEL_EN is defined.
module servant_spi_ram_slave #(
  parameter int ADDRESS_WIDTH = 24
) (
  input  logic                   clock,
  input  logic                   reset,
  servant_spi_ram_slave_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CMD        = 3'd1,
    ADDR       = 3'd2,
    READ_DATA  = 3'd3,
    WRITE_DATA = 3'd4,
    STATUS     = 3'd5,
    IGNORE     = 3'd6
  } state_e;

  logic [1:0] sckSync_q, ssSync_q, mosiSync_q;
  logic       sckPrev_q;

  state_e                   state_q, state_d;
  logic [4:0]               bitCnt_q, bitCnt_d;
  logic [22:0]              rxShift_q, rxShift_d;
  logic [7:0]               txShift_q, txShift_d;
  logic                     miso_q, miso_d;
  logic                     oe_q, oe_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]               wdata_q, wdata_d;
  logic                     we_q, we_d;
  logic                     re_q, re_d;
  logic                     loadTx_q, loadTx_d;
  logic                     incAddr_q, incAddr_d;
  logic                     isRead_q, isRead_d;

  logic        sckRise, sckFall, ssHigh, mosiBit, lastBit;
  logic [7:0]  rxByte;
  logic [23:0] addrFull;
  logic [7:0]  statusByte;
  logic        writeAllowed;

`ifdef SPI_RAM_SLAVE_WEL_EN
  logic wel_q, wel_d;
  assign statusByte   = {6'b0, wel_q, 1'b0};
  assign writeAllowed = wel_q;
`else
  assign statusByte   = 8'h00;
  assign writeAllowed = 1'b1;
`endif

  // Synchronizers reset to the idle levels so no edge is seen on reset release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sckSync_q  <= 2'b11;
      ssSync_q   <= 2'b11;
      mosiSync_q <= 2'b00;
      sckPrev_q  <= 1'b1;
    end else begin
      sckSync_q  <= {sckSync_q[0], bus.spi_sck};
      ssSync_q   <= {ssSync_q[0], bus.spi_ss};
      mosiSync_q <= {mosiSync_q[0], bus.spi_mosi};
      sckPrev_q  <= sckSync_q[1];
    end
  end

  assign sckRise  = sckSync_q[1] & ~sckPrev_q;
  assign sckFall  = ~sckSync_q[1] & sckPrev_q;
  assign ssHigh   = ssSync_q[1];
  assign mosiBit  = mosiSync_q[1];
  assign rxByte   = {rxShift_q[6:0], mosiBit};
  assign addrFull = {rxShift_q, mosiBit};
  assign lastBit  = (state_q == ADDR) ? (bitCnt_q == 5'd23) : (bitCnt_q == 5'd7);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bitCnt_q  <= '0;
      rxShift_q <= '0;
      txShift_q <= '0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      loadTx_q  <= 1'b0;
      incAddr_q <= 1'b0;
      isRead_q  <= 1'b0;
`ifdef SPI_RAM_SLAVE_WEL_EN
      wel_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      rxShift_q <= rxShift_d;
      txShift_q <= txShift_d;
      miso_q    <= miso_d;
      oe_q      <= oe_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      loadTx_q  <= loadTx_d;
      incAddr_q <= incAddr_d;
      isRead_q  <= isRead_d;
`ifdef SPI_RAM_SLAVE_WEL_EN
      wel_q     <= wel_d;
`endif
    end
  end

  // Read data arrives one cycle after mem_re, so loadTx trails mem_re by one cycle.
  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    rxShift_d = rxShift_q;
    txShift_d = txShift_q;
    miso_d    = miso_q;
    oe_d      = oe_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    loadTx_d  = re_q;
    incAddr_d = 1'b0;
    isRead_d  = isRead_q;
`ifdef SPI_RAM_SLAVE_WEL_EN
    wel_d     = wel_q;
`endif

    if (incAddr_q) addr_d = addr_q + ADDRESS_WIDTH'(1);
    if (loadTx_q) txShift_d = bus.mem_rdata;

    if (ssHigh) begin
      state_d  = IDLE;
      bitCnt_d = '0;
      miso_d   = 1'b0;
      oe_d     = 1'b0;
    end else if (state_q == IDLE) begin
      state_d  = CMD;
      bitCnt_d = '0;
    end else begin
      if (sckRise) begin
        rxShift_d = {rxShift_q[21:0], mosiBit};
        bitCnt_d  = lastBit ? 5'd0 : bitCnt_q + 5'd1;
      end
      if (sckFall && (state_q == READ_DATA || state_q == STATUS)) begin
        miso_d    = txShift_q[7];
        txShift_d = {txShift_q[6:0], 1'b0};
      end
      if (sckRise && lastBit) begin
        unique case (state_q)
          CMD: begin
            state_d = IGNORE;
            case (rxByte)
`ifdef SPI_RAM_SLAVE_WEL_EN
              8'h06: wel_d = 1'b1;
              8'h04: wel_d = 1'b0;
`endif
              8'h05: begin
                state_d   = STATUS;
                txShift_d = statusByte;
                oe_d      = 1'b1;
              end
              8'h03: begin
                state_d  = ADDR;
                isRead_d = 1'b1;
              end
              8'h02: begin
                state_d  = ADDR;
                isRead_d = 1'b0;
              end
              default: state_d = IGNORE;
            endcase
          end
          ADDR: begin
            addr_d = addrFull[ADDRESS_WIDTH-1:0];
            if (isRead_q) begin
              state_d = READ_DATA;
              re_d    = 1'b1;
              oe_d    = 1'b1;
            end else begin
              state_d = WRITE_DATA;
            end
          end
          READ_DATA: begin
            addr_d = addr_q + ADDRESS_WIDTH'(1);
            re_d   = 1'b1;
          end
          WRITE_DATA: begin
            wdata_d   = rxByte;
            we_d      = writeAllowed;
            incAddr_d = 1'b1;
          end
          STATUS:  txShift_d = statusByte;
          default: ;
        endcase
      end
    end
  end

  assign bus.spi_miso    = miso_q;
  assign bus.spi_miso_oe = oe_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_we      = we_q;
  assign bus.mem_re      = re_q;

endmodule
